bram_seq_ctrl: RTL and testbench

//  Sequencer directly upstream of bram_example. It drives the BRAM we/addr/w_data ports.

---
 rtl/bram_seq_if.sv | 33 +++
 rtl/bram_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_bram_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_seq_if.sv
// Stream and BRAM bus bundle for bram_seq_ctrl.
//  in_valid/in_data/in_last/in_ready : LOAD-side word stream (producer -> sequencer)
//  out_valid/out_data/out_ready      : PLAY-side word stream (sequencer -> consumer)
//  bram_we/bram_addr/bram_w_data     : write/address port toward bram_example
//  bram_r_data                       : synchronous read data from bram_example
// modport slave  : the sequencer's view
// modport master : the surrounding environment's view (producer, consumer, BRAM)
interface bram_seq_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_w_data;
  logic [DATA_W-1:0] bram_r_data;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, bram_r_data,
    output in_ready, out_valid, out_data, bram_we, bram_addr, bram_w_data
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, bram_r_data,
    input  in_ready, out_valid, out_data, bram_we, bram_addr, bram_w_data
  );
endinterface

// File: rtl/bram_seq_ctrl.sv
// Load/playback sequencer sitting in front of bram_example.
// LOAD streams words into consecutive BRAM addresses from 0; PLAY reads them
// back in order (RD -> WAIT -> OUT per word, so 3 cycles/word minimum).
// Ports:
//  clk, rst     : rising-edge clock, synchronous active-high reset
//  start_load   : pulse, begins LOAD (only honoured in IDLE, wins over start_play)
//  start_play   : pulse, begins PLAY (only honoured in IDLE)
//  busy         : state != IDLE
//  done         : registered one-cycle pulse in the first IDLE cycle after LOAD/PLAY
//  count        : number of words stored by the last LOAD
//  bus          : stream and BRAM signals (see bram_seq_if)
module bram_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_load,
  input  logic            start_play,
  output logic            busy,
  output logic            done,
  output logic [ADDR_W:0] count,
  bram_seq_if.slave       bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              done_r;
  logic              accept_s;
  logic              last_word_s;

  assign bus.in_ready    = (state_r == S_LOAD);
  assign accept_s        = bus.in_valid & bus.in_ready;
  assign bus.bram_we     = accept_s;
  assign bus.bram_addr   = ptr_r;
  assign bus.bram_w_data = bus.in_data;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign busy            = (state_r != S_IDLE);
  assign done            = done_r;
  assign count           = count_r;

  // In OUT, the word being presented is the final one when ptr == count-1.
  assign last_word_s = ({1'b0, ptr_r} == (count_r - ONE_C));

  // Sequencer FSM, pointer/fill counter and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_load) begin
            state_r <= S_LOAD;
            ptr_r   <= '0;
            count_r <= '0;
          end else if (start_play) begin
            if (count_r != '0) begin
              state_r <= S_RD;
              ptr_r   <= '0;
            end else begin
              // Nothing stored: report completion immediately.
              done_r <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            ptr_r   <= ptr_r + PTR_ONE_C;
            count_r <= count_r + ONE_C;
            // Leaving on the DEPTH-th accept drops in_ready, so no wrap/overwrite.
            if (bus.in_last || ((count_r + ONE_C) == DEPTH_L)) begin
              state_r <= S_IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_LOAD;
            end
          end else begin
            state_r <= S_LOAD;
          end
        end
        S_RD: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // BRAM read data for ptr is valid during this cycle.
          out_data_r  <= bus.bram_r_data;
          out_valid_r <= 1'b1;
          state_r     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (last_word_s) begin
              state_r <= S_IDLE;
              done_r  <= 1'b1;
            end else begin
              ptr_r   <= ptr_r + PTR_ONE_C;
              state_r <= S_RD;
            end
          end else begin
            state_r <= S_OUT;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_seq_ctrl.sv
module tb_bram_seq_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_load;
  logic            start_play;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] count;

  bram_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif();

  bram_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_play(start_play),
    .busy(busy), .done(done), .count(count), .bus(bif.slave)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: synchronous write, synchronous read (old data on collision).
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bif.bram_we) mem[bif.bram_addr] <= bif.bram_w_data;
    bif.bram_r_data <= mem[bif.bram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0]        exp_out[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr[$];
  logic [DATA_W-1:0]        model [DEPTH];
  int exp_count = 0;
  bit check_gap = 1'b0;
  int prev_cyc  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: BRAM writes and output handshakes are checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.bram_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", {bif.bram_addr, bif.bram_w_data}, 32'hFFFF);
        else check("bram_write", {bif.bram_addr, bif.bram_w_data}, exp_wr.pop_front());
      end
      if (bif.out_valid && bif.out_ready) begin
        if (exp_out.size() == 0) check("unexpected_out", bif.out_data, 32'hFFFF);
        else check("out_data", bif.out_data, exp_out.pop_front());
        if (check_gap && prev_cyc >= 0) check("out_gap", cyc - prev_cyc, 3);
        prev_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit ld, input bit pl);
    start_load = ld; start_play = pl;
    tick();
    start_load = 1'b0; start_play = 1'b0;
  endtask

  task automatic load_words(input int n, input bit use_last, input int base);
    pulse_start(1'b1, 1'b0);
    exp_count = 0;
    for (int i = 0; i < n; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = DATA_W'(base + i);
      bif.in_last  = use_last && (i == n - 1);
      if (i < DEPTH) begin
        exp_wr.push_back({ADDR_W'(i), DATA_W'(base + i)});
        model[i] = DATA_W'(base + i);
        exp_count = i + 1;
      end else begin
        check("in_ready_after_full", bif.in_ready, 0);
      end
      tick();
    end
    bif.in_valid = 1'b0; bif.in_last = 1'b0;
  endtask

  task automatic push_play();
    for (int i = 0; i < exp_count; i++) exp_out.push_back(model[i]);
  endtask

  task automatic wait_done(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) break;
    end
    check(name, done, 1);
    check("busy_at_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  task automatic wait_valid(input string name, input int max);
    for (int i = 0; i < max && !bif.out_valid; i++) tick();
    check(name, bif.out_valid, 1);
  endtask

  logic [DATA_W-1:0] held;

  initial begin
    rst = 1'b1; start_load = 1'b0; start_play = 1'b0;
    bif.in_valid = 1'b0; bif.in_data = '0; bif.in_last = 1'b0; bif.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    // 1. Reset state
    check("rst_out_valid", bif.out_valid, 0);
    check("rst_in_ready", bif.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_bram_we", bif.bram_we, 0);
    check("rst_done", done, 0);
    // PLAY with nothing stored: immediate done, stays IDLE
    pulse_start(1'b0, 1'b1);
    check("empty_play_done", done, 1);
    check("empty_play_busy", busy, 0);

    // 2. LOAD 3,7,A,F
    pulse_start(1'b1, 1'b0);
    check("load_in_ready", bif.in_ready, 1);
    exp_count = 0;
    begin
      logic [DATA_W-1:0] v [4];
      v[0] = 4'h3; v[1] = 4'h7; v[2] = 4'hA; v[3] = 4'hF;
      for (int i = 0; i < 4; i++) begin
        bif.in_valid = 1'b1; bif.in_data = v[i]; bif.in_last = (i == 3);
        exp_wr.push_back({ADDR_W'(i), v[i]});
        model[i] = v[i];
        tick();
      end
      exp_count = 4;
    end
    bif.in_valid = 1'b0; bif.in_last = 1'b0;
    check("load4_done", done, 1);
    check("load4_count", count, 4);
    check("load4_busy", busy, 0);
    tick();
    check("load4_done_clear", done, 0);
    check("load4_writes", exp_wr.size(), 0);

    // 3. PLAY with out_ready high: 3 cycles/word
    bif.out_ready = 1'b1; check_gap = 1'b1; prev_cyc = -1;
    push_play();
    pulse_start(1'b0, 1'b1);
    wait_done("play4_done", 40);
    check_gap = 1'b0;
    check("play4_drained", exp_out.size(), 0);
    check("play4_count_kept", count, 4);

    // 4. LOAD 32 words (no in_last) plus a 33rd that must not be written
    load_words(33, 1'b0, 0);
    check("full_count", count, 32);
    check("full_in_ready", bif.in_ready, 0);
    check("full_writes", exp_wr.size(), 0);

    // 5. PLAY with a 5-cycle stall on word 1
    bif.out_ready = 1'b0;
    push_play();
    pulse_start(1'b0, 1'b1);
    wait_valid("stall_w0_valid", 10);
    bif.out_ready = 1'b1; tick(); bif.out_ready = 1'b0;
    wait_valid("stall_w1_valid", 10);
    held = bif.out_data;
    check("stall_w1_value", held, model[1]);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid_held", bif.out_valid, 1);
      check("stall_data_stable", bif.out_data, held);
    end
    bif.out_ready = 1'b1;
    wait_done("play32_done", 200);
    check("play32_drained", exp_out.size(), 0);

    // 6. Simultaneous starts: load wins
    bif.out_ready = 1'b0;
    start_load = 1'b1; start_play = 1'b1;
    tick();
    start_load = 1'b0; start_play = 1'b0;
    check("both_start_in_ready", bif.in_ready, 1);
    exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      bif.in_valid = 1'b1; bif.in_data = DATA_W'(5 + i); bif.in_last = (i == 2);
      exp_wr.push_back({ADDR_W'(i), DATA_W'(5 + i)});
      model[i] = DATA_W'(5 + i);
      tick();
    end
    exp_count = 3;
    bif.in_valid = 1'b0; bif.in_last = 1'b0;
    check("load3_count", count, 3);
    // Reset while word 2 is presented
    push_play();
    pulse_start(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_valid("rstplay_valid", 10);
      bif.out_ready = 1'b1; tick(); bif.out_ready = 1'b0;
    end
    wait_valid("rstplay_w2_valid", 10);
    check("rstplay_w2_data", bif.out_data, model[2]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_out.delete();
    check("midrst_out_valid", bif.out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bif.in_ready, 0);
    pulse_start(1'b0, 1'b1);
    check("postrst_empty_done", done, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
